// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the RV32 fetch/decode boundary.
// Holds the fetch FSM states, the IF/ID payload struct and the PC legality check.
package rv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    // A PC is fetchable only when word aligned and inside the instruction memory.
    function automatic logic is_legal_pc(input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] limit_bytes);
        return (pc[1:0] == 2'b00) && (pc < limit_bytes);
    endfunction

endpackage

// File: rtl/pc_register.sv
// Fetch program counter: PC flop, redirect/stall next-PC mux and the +4 adder.
// Redirect beats stall; hold freezes the PC completely (used during BOOT).
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic        stall,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);
    import rv_pipe_pkg::*;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (!hold) begin
            if (redirect) begin
                pc <= target;
            end else if (!stall) begin
                pc <= pc_plus4;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register, fetch FSM and sticky fault.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR  = rv_pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);
    import rv_pipe_pkg::*;

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    fetch_state_t state_q, state_d;
    if_id_t       if_id_q, if_id_d;
    logic         fault_q, fault_d;
    logic [31:0]  pc_plus4_f;
    logic         pc_legal;
    logic         load_valid;
    logic         load_bubble;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk      (clk),
        .reset    (reset),
        .hold     (state_q == BOOT),
        .redirect (pc_src_e),
        .stall    (stall_f),
        .target   (pc_target_e),
        .pc       (pc_f),
        .pc_plus4 (pc_plus4_f)
    );

    assign imem_addr = pc_f;
    assign pc_legal  = is_legal_pc(pc_f, IMEM_BYTES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            if_id_q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if_id_q <= if_id_d;
            fault_q <= fault_d;
        end
    end

    // IF/ID capture: flush beats stall; BOOT, FAULT and illegal PCs capture a NOP.
    always_comb begin
        state_d     = state_q;
        if_id_d     = if_id_q;
        fault_d     = fault_q;
        load_valid  = 1'b0;
        load_bubble = 1'b0;

        if (flush_d) begin
            if_id_d     = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
            load_bubble = 1'b1;
        end else if (!stall_d) begin
            if (state_q == BOOT) begin
                if_id_d     = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
                load_bubble = 1'b1;
            end else if (state_q == FAULT || !pc_legal) begin
                if_id_d     = '{instr: NOP_INSTR, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b0};
                load_bubble = 1'b1;
                if (!pc_legal) begin
                    fault_d = 1'b1;
                end
            end else begin
                if_id_d    = '{instr: imem_rd, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};
                load_valid = 1'b1;
            end
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!flush_d && !stall_d && !pc_legal) state_d = FAULT;
            FAULT:   if (pc_src_e && is_legal_pc(pc_target_e, IMEM_BYTES)) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    assign instr_d     = if_id_q.instr;
    assign pc_d        = if_id_q.pc;
    assign pc_plus4_d  = if_id_q.pc_plus4;
    assign valid_d     = if_id_q.valid;
    assign fetch_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters; stall_d holds load neither counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load_valid && perf_fetched != 32'hFFFF_FFFF) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (load_bubble && perf_bubbles != 32'hFFFF_FFFF) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = load_valid ^ load_bubble;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage with an 8-word memory.
// Perf counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr, imem_rd, pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    logic [31:0] mem [0:7];
    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    assign imem_rd = (imem_addr < 32'd32) ? mem[imem_addr[4:2]] : 32'hDEAD_BEEF;

    instruction_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (8),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .fetch_fault (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #12;
        n_compared++; if (pc_f !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_pc_f: got %h want %h", pc_f, 32'h0); end
        n_compared++; if (instr_d !== NOP) begin n_mismatched++; $display("[TB] FAIL reset_instr_d: got %h want %h", instr_d, NOP); end
        n_compared++; if (valid_d !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid_d: got %b want 0", valid_d); end
        n_compared++; if (pc_d !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_pc_d: got %h want 0", pc_d); end
        n_compared++; if (fetch_fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_fault: got %b want 0", fetch_fault); end
`ifdef FETCH_PERF_CNT_EN
        n_compared++; if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_perf: got %h/%h want 0/0", perf_fetched, perf_bubbles); end
`endif
    endtask

    task automatic test_boot_sequence();
        reset = 1'b0;
        tick();
        n_compared++; if (valid_d !== 1'b0) begin n_mismatched++; $display("[TB] FAIL boot_valid: got %b want 0", valid_d); end
        n_compared++; if (pc_f !== 32'h0) begin n_mismatched++; $display("[TB] FAIL boot_pc_f: got %h want 0", pc_f); end
        tick();
        n_compared++; if (instr_d !== 32'h0320_0513) begin n_mismatched++; $display("[TB] FAIL seq0_instr: got %h want 03200513", instr_d); end
        n_compared++; if (pc_d !== 32'h0 || pc_plus4_d !== 32'h4) begin n_mismatched++; $display("[TB] FAIL seq0_pc: got %h/%h want 0/4", pc_d, pc_plus4_d); end
        n_compared++; if (valid_d !== 1'b1) begin n_mismatched++; $display("[TB] FAIL seq0_valid: got %b want 1", valid_d); end
        tick();
        n_compared++; if (instr_d !== 32'h01E0_0393 || pc_d !== 32'h4) begin n_mismatched++; $display("[TB] FAIL seq1: got %h@%h want 01e00393@4", instr_d, pc_d); end
        n_compared++; if (imem_addr !== 32'h8) begin n_mismatched++; $display("[TB] FAIL seq1_imem_addr: got %h want 8", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_compared++; if (perf_fetched !== 32'd2 || perf_bubbles !== 32'd1) begin n_mismatched++; $display("[TB] FAIL seq_perf: got %0d/%0d want 2/1", perf_fetched, perf_bubbles); end
`endif
        tick();
        n_compared++; if (instr_d !== mem[2] || pc_f !== 32'hC) begin n_mismatched++; $display("[TB] FAIL seq2: got %h pc_f %h want %h pc_f c", instr_d, pc_f, mem[2]); end
    endtask

    task automatic test_load_use_stall();
        stall_f = 1; stall_d = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_compared++; if (pc_f !== 32'hC || instr_d !== mem[2] || pc_d !== 32'h8) begin n_mismatched++; $display("[TB] FAIL stall_hold%0d: got pc_f %h instr %h pc_d %h want c %h 8", i, pc_f, instr_d, pc_d, mem[2]); end
        end
        clear_inputs();
        tick();
        n_compared++; if (instr_d !== mem[3] || pc_d !== 32'hC || pc_f !== 32'h10) begin n_mismatched++; $display("[TB] FAIL stall_resume: got %h@%h pc_f %h want %h@c pc_f 10", instr_d, pc_d, pc_f, mem[3]); end
    endtask

    task automatic test_redirect();
        pc_src_e = 1; pc_target_e = 32'h4; flush_d = 1; stall_f = 1;
        tick();
        n_compared++; if (pc_f !== 32'h4) begin n_mismatched++; $display("[TB] FAIL redir_pc_f: got %h want 4", pc_f); end
        n_compared++; if (instr_d !== NOP || valid_d !== 1'b0 || pc_d !== 32'h0) begin n_mismatched++; $display("[TB] FAIL redir_bubble: got %h v%b pc_d %h want %h v0 0", instr_d, valid_d, pc_d, NOP); end
        clear_inputs();
        tick();
        n_compared++; if (instr_d !== mem[1] || pc_d !== 32'h4 || valid_d !== 1'b1 || pc_f !== 32'h8) begin n_mismatched++; $display("[TB] FAIL redir_target: got %h@%h v%b pc_f %h want %h@4 v1 8", instr_d, pc_d, valid_d, pc_f, mem[1]); end
    endtask

    task automatic test_flush_vs_stall();
        flush_d = 1; stall_d = 1; stall_f = 1;
        tick();
        n_compared++; if (instr_d !== 32'h0000_0013 || valid_d !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_beats_stall: got %h v%b want 00000013 v0", instr_d, valid_d); end
        n_compared++; if (pc_f !== 32'h8) begin n_mismatched++; $display("[TB] FAIL flush_pc_hold: got %h want 8", pc_f); end
        clear_inputs();
        tick();
        n_compared++; if (instr_d !== mem[2] || pc_f !== 32'hC) begin n_mismatched++; $display("[TB] FAIL flush_resume: got %h pc_f %h want %h c", instr_d, pc_f, mem[2]); end
    endtask

    task automatic test_range_fault();
        for (int w = 3; w < 8; w++) begin
            tick();
            n_compared++; if (instr_d !== mem[w] || pc_d !== 32'(w * 4) || valid_d !== 1'b1) begin n_mismatched++; $display("[TB] FAIL run_word%0d: got %h@%h v%b want %h@%h v1", w, instr_d, pc_d, valid_d, mem[w], w * 4); end
        end
        n_compared++; if (pc_f !== 32'h20 || fetch_fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pre_fault: got pc_f %h f%b want 20 f0", pc_f, fetch_fault); end
        tick();
        n_compared++; if (instr_d !== NOP || valid_d !== 1'b0 || fetch_fault !== 1'b1) begin n_mismatched++; $display("[TB] FAIL range_fault: got %h v%b f%b want %h v0 f1", instr_d, valid_d, fetch_fault, NOP); end
        pc_src_e = 1; pc_target_e = 32'h0; flush_d = 1;
        tick();
        n_compared++; if (pc_f !== 32'h0 || valid_d !== 1'b0 || fetch_fault !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fault_redirect: got pc_f %h v%b f%b want 0 v0 f1", pc_f, valid_d, fetch_fault); end
        clear_inputs();
        tick();
        n_compared++; if (instr_d !== mem[0] || valid_d !== 1'b1 || fetch_fault !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fault_recover: got %h v%b f%b want %h v1 f1", instr_d, valid_d, fetch_fault, mem[0]); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) tick();
        n_compared++; if (pc_f !== 32'h18) begin n_mismatched++; $display("[TB] FAIL pre_reset_pc: got %h want 18", pc_f); end
        pc_src_e = 1; pc_target_e = 32'h10;
        #2;
        reset = 1'b1;
        #1;
        n_compared++; if (pc_f !== 32'h0 || valid_d !== 1'b0 || fetch_fault !== 1'b0 || instr_d !== NOP) begin n_mismatched++; $display("[TB] FAIL async_reset: got pc_f %h v%b f%b %h want 0 v0 f0 %h", pc_f, valid_d, fetch_fault, instr_d, NOP); end
`ifdef FETCH_PERF_CNT_EN
        n_compared++; if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin n_mismatched++; $display("[TB] FAIL async_reset_perf: got %h/%h want 0/0", perf_fetched, perf_bubbles); end
`endif
        clear_inputs();
        #1;
        reset = 1'b0;
        tick();
        n_compared++; if (pc_f !== 32'h0 || valid_d !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reboot: got pc_f %h v%b want 0 v0", pc_f, valid_d); end
    endtask

    task automatic test_misaligned();
        pc_src_e = 1; pc_target_e = 32'h2; flush_d = 1;
        tick();
        n_compared++; if (pc_f !== 32'h2 || fetch_fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL misalign_redirect: got pc_f %h f%b want 2 f0", pc_f, fetch_fault); end
        clear_inputs();
        tick();
        n_compared++; if (instr_d !== NOP || valid_d !== 1'b0 || fetch_fault !== 1'b1) begin n_mismatched++; $display("[TB] FAIL misalign_fault: got %h v%b f%b want %h v0 f1", instr_d, valid_d, fetch_fault, NOP); end
    endtask

    initial begin
        mem[0] = 32'h0320_0513; mem[1] = 32'h01E0_0393;
        mem[2] = 32'h00A0_0093; mem[3] = 32'h00B0_0113;
        mem[4] = 32'h00C0_0193; mem[5] = 32'h00D0_0213;
        mem[6] = 32'h00E0_0293; mem[7] = 32'h00F0_0313;
        test_reset();
        test_boot_sequence();
        test_load_use_stall();
        test_redirect();
        test_flush_vs_stall();
        test_range_fault();
        test_async_reset();
        test_misaligned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
